// File: rtl/cordic_pkg.sv
// Shared CORDIC constants and the requester tag carried alongside the pipeline.
package cordic_pkg;

  localparam int unsigned CORDIC_WIDTH   = 17;
  localparam int unsigned CORDIC_LATENCY = 17;

  // One tag per CORDIC pipeline slot: occupied flag plus issuing requester.
  typedef struct packed {
    logic       valid;
    logic [2:0] id;
  } cordic_tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched upward from a rotating pointer.
module rr_arbiter #(
  parameter int unsigned N = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int unsigned PW = $clog2(N);

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_win;
  logic [N-1:0]  w_grant;

  // First requester at or above the pointer, wrapping around.
  always_comb begin
    logic [PW-1:0] idx;
    w_grant = '0;
    w_win   = '0;
    idx     = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = PW'((32'(r_ptr) + k) % N);
      if (req[idx] && (w_grant == '0)) begin
        w_grant[idx] = 1'b1;
        w_win        = idx;
      end
    end
  end

  // Pointer moves just past the winner; it stays put when nobody is granted.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (advance && (w_grant != '0)) begin
      r_ptr <= (w_win == PW'(N - 1)) ? '0 : w_win + PW'(1);
    end
  end

  assign grant = w_grant;

endmodule

// File: rtl/cordic_arbiter.sv
// Shares one pipelined CORDIC between requesters and steers results back by tag.
module cordic_arbiter
  import cordic_pkg::*;
#(
  parameter int unsigned N_REQ   = 2,
  parameter int unsigned WIDTH   = CORDIC_WIDTH,
  parameter int unsigned LATENCY = CORDIC_LATENCY
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_x,
  input  logic [N_REQ*WIDTH-1:0] req_y,
  input  logic [N_REQ*WIDTH-1:0] req_z,
  output logic [N_REQ-1:0]       rsp_valid,
  output logic [WIDTH:0]         rsp_x,
  output logic [WIDTH:0]         rsp_y,
  output logic [WIDTH-1:0]       rsp_z,
  output logic                   cordic_en,
  output logic [WIDTH-1:0]       cordic_x0,
  output logic [WIDTH-1:0]       cordic_y0,
  output logic [WIDTH-1:0]       cordic_z0,
  input  logic [WIDTH:0]         cordic_x,
  input  logic [WIDTH:0]         cordic_y,
  input  logic [WIDTH-1:0]       cordic_z
);

  logic [N_REQ-1:0] w_req;
  logic [N_REQ-1:0] w_grant;
  logic             w_issue;
  logic [2:0]       w_id;
  logic [WIDTH-1:0] w_sel_x, w_sel_y, w_sel_z;

  cordic_tag_t      r_tag     [LATENCY+1];
  cordic_tag_t      w_tag_nxt [LATENCY+1];
  logic             w_en_nxt;
  logic             r_en;

  logic [WIDTH-1:0] r_x0, r_y0, r_z0;
  logic [N_REQ-1:0] w_rsp_dec;
  logic [N_REQ-1:0] r_rsp_valid;
  logic [WIDTH:0]   r_rsp_x, r_rsp_y;
  logic [WIDTH-1:0] r_rsp_z;

  // No grants are offered while reset is held.
  assign w_req = reset ? '0 : req_valid;

  rr_arbiter #(.N(N_REQ)) u_rr (
    .clk     (clk),
    .reset   (reset),
    .req     (w_req),
    .advance (~reset),
    .grant   (w_grant)
  );

  // Winner's operands and id, picked from the one-hot grant.
  always_comb begin
    w_issue = 1'b0;
    w_id    = '0;
    w_sel_x = '0;
    w_sel_y = '0;
    w_sel_z = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (w_grant[i]) begin
        w_issue = 1'b1;
        w_id    = 3'(i);
        w_sel_x = req_x[i*WIDTH +: WIDTH];
        w_sel_y = req_y[i*WIDTH +: WIDTH];
        w_sel_z = req_z[i*WIDTH +: WIDTH];
      end
    end
  end

  // Stage 0 mirrors the operand register; deeper stages move only with the CORDIC.
  // Stage 0 valid is exactly "granted last cycle", so the enable is the OR of all stages.
  always_comb begin
    w_tag_nxt    = r_tag;
    w_tag_nxt[0] = '{valid: w_issue, id: w_id};
    if (r_en) begin
      for (int unsigned k = 1; k <= LATENCY; k++) begin
        w_tag_nxt[k] = r_tag[k-1];
      end
    end
    w_en_nxt = 1'b0;
    for (int unsigned k = 0; k <= LATENCY; k++) begin
      w_en_nxt = w_en_nxt | w_tag_nxt[k].valid;
    end
  end

  // Tag pipeline and CORDIC enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tag <= '{default: '0};
      r_en  <= 1'b0;
    end else begin
      r_tag <= w_tag_nxt;
      r_en  <= w_en_nxt;
    end
  end

  // Operand registers hold between grants.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_x0 <= '0;
      r_y0 <= '0;
      r_z0 <= '0;
    end else if (w_issue) begin
      r_x0 <= w_sel_x;
      r_y0 <= w_sel_y;
      r_z0 <= w_sel_z;
    end
  end

  // Decode the tag leaving the pipeline into a per-requester strobe.
  always_comb begin
    w_rsp_dec = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      w_rsp_dec[i] = r_tag[LATENCY].valid && (r_tag[LATENCY].id == 3'(i));
    end
  end

  // Result capture, aligned with the tag that completes this cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rsp_valid <= '0;
      r_rsp_x     <= '0;
      r_rsp_y     <= '0;
      r_rsp_z     <= '0;
    end else begin
      r_rsp_valid <= w_rsp_dec;
      if (w_rsp_dec != '0) begin
        r_rsp_x <= cordic_x;
        r_rsp_y <= cordic_y;
        r_rsp_z <= cordic_z;
      end
    end
  end

  assign req_ready = w_grant;
  assign rsp_valid = r_rsp_valid;
  assign rsp_x     = r_rsp_x;
  assign rsp_y     = r_rsp_y;
  assign rsp_z     = r_rsp_z;
  assign cordic_en = r_en;
  assign cordic_x0 = r_x0;
  assign cordic_y0 = r_y0;
  assign cordic_z0 = r_z0;

endmodule

// File: tb/tb_cordic_arbiter.sv
// Bench for cordic_arbiter: arbitration table, corner sequences and a random scoreboard run.
module tb_cordic_arbiter;

  localparam int N = 2;
  localparam int W = 17;
  localparam int L = 17;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid, req_ready, rsp_valid;
  logic [N*W-1:0] req_x, req_y, req_z;
  logic [W:0]     rsp_x, rsp_y;
  logic [W-1:0]   rsp_z;
  logic           cordic_en;
  logic [W-1:0]   cordic_x0, cordic_y0, cordic_z0;
  logic [W:0]     cordic_x, cordic_y;
  logic [W-1:0]   cordic_z;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cordic_arbiter #(.N_REQ(N), .WIDTH(W), .LATENCY(L)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_z(req_z),
    .rsp_valid(rsp_valid), .rsp_x(rsp_x), .rsp_y(rsp_y), .rsp_z(rsp_z),
    .cordic_en(cordic_en),
    .cordic_x0(cordic_x0), .cordic_y0(cordic_y0), .cordic_z0(cordic_z0),
    .cordic_x(cordic_x), .cordic_y(cordic_y), .cordic_z(cordic_z)
  );

  typedef struct packed {
    logic [W:0]   x;
    logic [W:0]   y;
    logic [W-1:0] z;
  } res_t;

  // Stand-in CORDIC datapath: an arbitrary but operand-dependent result per slot.
  function automatic res_t fake_cordic(input logic [W-1:0] x0, input logic [W-1:0] y0,
                                       input logic [W-1:0] z0);
    res_t r;
    r.x = {x0[W-1], x0} + {z0[W-1], z0};
    r.y = {y0[W-1], y0} - {z0[W-1], z0};
    r.z = z0 ^ W'('h155A);
    return r;
  endfunction

  // Enabled pipeline of depth L: sampled on an enabled edge, visible L enabled edges later.
  res_t pipe [L];
  always @(posedge clk) begin
    if (cordic_en) begin
      pipe[0] <= fake_cordic(cordic_x0, cordic_y0, cordic_z0);
      for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
    end
  end
  assign cordic_x = pipe[L-1].x;
  assign cordic_y = pipe[L-1].y;
  assign cordic_z = pipe[L-1].z;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic int model_winner(input logic [N-1:0] rv, input int p);
    for (int k = 0; k < N; k++) if (rv[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  // Reference: each grant at cycle t keeps the CORDIC busy for t+1..t+L+1 and answers at t+L+2.
  typedef struct {
    int   t;
    int   id;
    res_t r;
  } op_t;

  op_t            inflight[$];
  op_t            m_op;
  int             m_ptr = 0;
  int             m_w;
  logic [W-1:0]   m_x0 = '0, m_y0 = '0, m_z0 = '0;
  logic [N-1:0]   m_gnt, m_rsp;
  logic           m_en;
  res_t           m_res;

  always @(negedge clk) begin
    if (cyc > 0) begin
      m_w   = reset ? -1 : model_winner(req_valid, m_ptr);
      m_gnt = (m_w >= 0) ? N'(1) << m_w : '0;
      m_en  = 1'b0;
      m_rsp = '0;
      m_res = '0;
      foreach (inflight[q]) begin
        if (cyc >= inflight[q].t + 1 && cyc <= inflight[q].t + L + 1) m_en = 1'b1;
        if (cyc == inflight[q].t + L + 2) begin
          m_rsp = N'(1) << inflight[q].id;
          m_res = inflight[q].r;
        end
      end
      check("req_ready", 64'(req_ready), 64'(m_gnt));
      check("cordic_en", 64'(cordic_en), 64'(m_en));
      check("rsp_valid", 64'(rsp_valid), 64'(m_rsp));
      check("cordic_x0", 64'({cordic_x0, cordic_y0, cordic_z0}), 64'({m_x0, m_y0, m_z0}));
      if (m_rsp != '0) begin
        check("rsp_x", 64'(rsp_x), 64'(m_res.x));
        check("rsp_y", 64'(rsp_y), 64'(m_res.y));
        check("rsp_z", 64'(rsp_z), 64'(m_res.z));
      end
      if (reset) begin
        inflight.delete();
        m_ptr = 0;
        m_x0  = '0;
        m_y0  = '0;
        m_z0  = '0;
      end else begin
        if (m_w >= 0) begin
          m_x0    = req_x[m_w*W +: W];
          m_y0    = req_y[m_w*W +: W];
          m_z0    = req_z[m_w*W +: W];
          m_op.t  = cyc;
          m_op.id = m_w;
          m_op.r  = fake_cordic(m_x0, m_y0, m_z0);
          inflight.push_back(m_op);
          m_ptr = (m_w + 1) % N;
        end
        while (inflight.size() > 0 && inflight[0].t + L + 2 <= cyc) void'(inflight.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      req_x[i*W +: W] = W'($urandom);
      req_y[i*W +: W] = W'($urandom);
      req_z[i*W +: W] = W'($urandom);
    end
  endtask

  task automatic issue(input logic [N-1:0] rv, output int t);
    req_valid = rv;
    t = cyc;
    step();
  endtask

  // Idle for n cycles, observing enable and responses.
  task automatic watch(input int n, output int en_cnt, output int first_rsp, output int last_rsp,
                       output int n0, output int n1, output res_t first_res);
    req_valid = '0;
    en_cnt = 0; first_rsp = -1; last_rsp = -1; n0 = 0; n1 = 0; first_res = '0;
    for (int k = 0; k < n; k++) begin
      #1;
      if (cordic_en) en_cnt++;
      if (rsp_valid != '0) begin
        if (first_rsp < 0) begin
          first_rsp = cyc;
          first_res = '{x: rsp_x, y: rsp_y, z: rsp_z};
        end
        last_rsp = cyc;
      end
      if (rsp_valid[0]) n0++;
      if (rsp_valid[1]) n1++;
      step();
    end
  endtask

  typedef struct {
    logic [N-1:0] rv;
    logic [N-1:0] gnt;
  } vec_t;

  vec_t tbl [10];
  int   t0, t1, en_cnt, f_rsp, l_rsp, n0, n1;
  res_t f_res;

  initial begin
    tbl[0] = '{rv: 2'b11, gnt: 2'b01};
    tbl[1] = '{rv: 2'b11, gnt: 2'b10};
    tbl[2] = '{rv: 2'b10, gnt: 2'b10};
    tbl[3] = '{rv: 2'b10, gnt: 2'b10};
    tbl[4] = '{rv: 2'b01, gnt: 2'b01};
    tbl[5] = '{rv: 2'b00, gnt: 2'b00};
    tbl[6] = '{rv: 2'b11, gnt: 2'b10};
    tbl[7] = '{rv: 2'b01, gnt: 2'b01};
    tbl[8] = '{rv: 2'b01, gnt: 2'b01};
    tbl[9] = '{rv: 2'b11, gnt: 2'b10};

    reset     = 1'b1;
    req_valid = 2'b11;
    rand_ops();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset_rsp_data", 64'({rsp_x, rsp_y, rsp_z}), 64'(0));

    // Arbitration vectors straight out of reset (pointer starts at 0).
    foreach (tbl[v]) begin
      req_valid = tbl[v].rv;
      rand_ops();
      #1;
      check("tbl_grant", 64'(req_ready), 64'(tbl[v].gnt));
      step();
    end
    watch(25, en_cnt, f_rsp, l_rsp, n0, n1, f_res);

    // Single operation from requester 1.
    req_x[W +: W] = W'('h0FFFF);
    req_y[W +: W] = W'(0);
    req_z[W +: W] = W'('h04000);
    issue(2'b10, t0);
    watch(25, en_cnt, f_rsp, l_rsp, n0, n1, f_res);
    check("single_rsp_cycle", 64'(f_rsp), 64'(t0 + L + 2));
    check("single_rsp_count", 64'({n0[7:0], n1[7:0]}), 64'({8'd0, 8'd1}));
    check("single_en_cycles", 64'(en_cnt), 64'(L + 1));
    check("single_rsp_data", 64'(f_res), 64'({18'h13FFF, 18'h3C000, 17'h0555A}));

    // Fairness: both requesters held for 10 cycles.
    t0 = cyc;
    for (int k = 0; k < 10; k++) begin
      rand_ops();
      req_valid = 2'b11;
      #1;
      check("fair_grant", 64'(req_ready), 64'((k % 2 == 0) ? 2'b01 : 2'b10));
      step();
    end
    watch(30, en_cnt, f_rsp, l_rsp, n0, n1, f_res);
    check("fair_first_rsp", 64'(f_rsp), 64'(t0 + L + 2));
    check("fair_last_rsp", 64'(l_rsp), 64'(t0 + L + 11));
    check("fair_counts", 64'({n0[7:0], n1[7:0]}), 64'({8'd5, 8'd5}));

    // Withdrawal: pointer at 1, requester 0 asserts for one cycle while 1 wins.
    issue(2'b01, t1);
    watch(25, en_cnt, f_rsp, l_rsp, n0, n1, f_res);
    req_valid = 2'b11;
    #1;
    check("withdraw_grant", 64'(req_ready), 64'(2'b10));
    step();
    watch(25, en_cnt, f_rsp, l_rsp, n0, n1, f_res);
    check("withdraw_counts", 64'({n0[7:0], n1[7:0]}), 64'({8'd0, 8'd1}));

    // Mid-flight reset: five issues, reset eight cycles later, nothing comes back.
    for (int k = 0; k < 5; k++) begin
      rand_ops();
      issue(2'b11, t1);
    end
    watch(8, en_cnt, f_rsp, l_rsp, n0, n1, f_res);
    reset = 1'b1;
    step();
    reset = 1'b0;
    watch(30, en_cnt, f_rsp, l_rsp, n0, n1, f_res);
    check("flush_rsp_count", 64'(n0 + n1), 64'(0));
    check("flush_en_cycles", 64'(en_cnt), 64'(0));
    req_valid = 2'b11;
    #1;
    check("flush_ptr_zero", 64'(req_ready), 64'(2'b01));
    step();
    watch(25, en_cnt, f_rsp, l_rsp, n0, n1, f_res);

    // Idle freeze: isolated operations 40 cycles apart.
    for (int k = 0; k < 3; k++) begin
      rand_ops();
      issue((k % 2 == 0) ? 2'b01 : 2'b10, t0);
      watch(40, en_cnt, f_rsp, l_rsp, n0, n1, f_res);
      check("idle_en_cycles", 64'(en_cnt), 64'(L + 1));
      check("idle_rsp_cycle", 64'(f_rsp), 64'(t0 + L + 2));
    end

    // Random traffic with occasional resets, checked by the reference model.
    for (int k = 0; k < 400; k++) begin
      rand_ops();
      req_valid = N'($urandom_range(0, 3));
      reset     = ($urandom_range(0, 99) == 0);
      step();
    end
    reset = 1'b0;
    watch(30, en_cnt, f_rsp, l_rsp, n0, n1, f_res);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
